// File: rtl/trace_feeder_pkg.sv
// trace_pkg: shared types and constants for the trace feeder block.
//   state_e : feeder FSM states
//   mode_e  : address pattern selector (RSVD behaves like SEQ)
//   LFSR_TAPS / LFSR_NONZERO_SEED : Galois LFSR constants for random mode
//   lfsr_step() : one Galois LFSR step (right shift, xor taps when bit 0 falls out)
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    LOOP = 2'd1,
    RAND = 2'd2,
    RSVD = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_NONZERO_SEED = 32'h0000_0001;

  // Taps 32,22,2,1 in Galois form: the bit shifted out of position 0
  // decides whether the tap mask is folded back into the register.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/trace_feeder_if.sv
// trace_feeder_if: address-trace handshake between the feeder and the cache.
//   trace_ready : feeder -> cache, mem_addr holds a valid unacknowledged address
//   mem_addr    : feeder -> cache, current trace address
//   updated     : cache -> feeder, one-cycle acknowledge of the current address
interface trace_feeder_if #(
  parameter int ADDR_W = 32
);
  logic              trace_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              updated;

  modport master (output trace_ready, output mem_addr, input updated);
  modport slave  (input trace_ready, input mem_addr, output updated);
endinterface

// File: rtl/trace_feeder_addr_gen.sv
// trace_addr_gen: address generator for the trace feeder.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : compute address 0 of a run from the held configuration
//   step_i      : advance to the next address of the run
//   mode_i      : pattern (SEQ/LOOP/RAND, RSVD acts as SEQ)
//   base_i      : first address, or LFSR seed in RAND mode
//   stride_i    : increment for SEQ/LOOP
//   loop_len_i  : LOOP period (0 treated as 1)
//   addr_o      : registered current address
module trace_addr_gen
  import trace_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                CNT_W     = 16,
  parameter logic [ADDR_W-1:0] RAND_MASK = 32'h0000_FFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  mode_e             mode_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  loop_len_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] accAddr_q, accAddr_d;
  logic [CNT_W-1:0]  loopIdx_q, loopIdx_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [CNT_W-1:0]  effLen;
  logic [CNT_W-1:0]  nextIdx;
  logic [ADDR_W-1:0] nextAcc;
  logic [31:0]       lfsrSeed;
  logic [31:0]       lfsrNext;

  // Next-address computation. The accumulator advances incrementally by
  // stride so SEQ wraps modulo 2^ADDR_W for free; LOOP snaps back to base
  // once the index would reach the loop length.
  always_comb begin
    accAddr_d = accAddr_q;
    loopIdx_d = loopIdx_q;
    lfsr_d    = lfsr_q;
    addr_d    = addr_q;

    effLen   = (loop_len_i == '0) ? CNT_W'(1) : loop_len_i;
    nextIdx  = loopIdx_q + CNT_W'(1);
    nextAcc  = accAddr_q + stride_i;
    lfsrSeed = (base_i == '0) ? LFSR_NONZERO_SEED : 32'(base_i);
    lfsrNext = lfsr_step(lfsr_q);

    if (load_i) begin
      accAddr_d = base_i;
      loopIdx_d = '0;
      lfsr_d    = lfsrSeed;
      addr_d    = (mode_i == RAND) ? (ADDR_W'(lfsrSeed) & RAND_MASK) : base_i;
    end else if (step_i) begin
      case (mode_i)
        LOOP: begin
          if (nextIdx >= effLen) begin
            loopIdx_d = '0;
            accAddr_d = base_i;
            addr_d    = base_i;
          end else begin
            loopIdx_d = nextIdx;
            accAddr_d = nextAcc;
            addr_d    = nextAcc;
          end
        end
        RAND: begin
          lfsr_d = lfsrNext;
          addr_d = ADDR_W'(lfsrNext) & RAND_MASK;
        end
        default: begin
          accAddr_d = nextAcc;
          addr_d    = nextAcc;
        end
      endcase
    end
  end

  // Generator state registers; the LFSR resets to 1 so it can never lock up.
  always_ff @(posedge clk) begin
    if (reset) begin
      accAddr_q <= '0;
      loopIdx_q <= '0;
      lfsr_q    <= LFSR_NONZERO_SEED;
      addr_q    <= '0;
    end else begin
      accAddr_q <= accAddr_d;
      loopIdx_q <= loopIdx_d;
      lfsr_q    <= lfsr_d;
      addr_q    <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/trace_feeder.sv
// trace_feeder: programmable address-trace source for the cache model.
//   clk, reset       : clock, synchronous active-high reset
//   start_i          : one-cycle pulse, starts a run from IDLE/DONE/ERROR
//   mode_i           : 0 sequential, 1 loop, 2 LFSR random, 3 as 0
//   base_addr_i      : first address / LFSR seed
//   stride_i         : address increment
//   loop_len_i       : loop period for mode 1
//   num_accesses_i   : addresses to issue in the run
//   bus              : trace_ready/mem_addr out, updated in (master side)
//   busy_o           : run in progress
//   done_o           : sticky, all accesses acknowledged
//   timeout_err_o    : sticky, acknowledge did not arrive within TIMEOUT cycles
//   issued_count_o   : acknowledged addresses in the current run
module trace_feeder
  import trace_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                CNT_W     = 16,
  parameter int                TIMEOUT   = 255,
  parameter logic [ADDR_W-1:0] RAND_MASK = 32'h0000_FFFC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W-1:0]    stride_i,
  input  logic [CNT_W-1:0]     loop_len_i,
  input  logic [CNT_W-1:0]     num_accesses_i,
  trace_feeder_if.master       bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_err_o,
  output logic [CNT_W-1:0]     issued_count_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  loopLen_q, loopLen_d;
  logic [CNT_W-1:0]  numAcc_q, numAcc_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              loadAddr;
  logic              stepAddr;
  logic [CNT_W-1:0]  issuedNext;
  logic [ADDR_W-1:0] genAddr;

  // Next-state logic. Configuration is captured only when a start is
  // accepted, so changes on the inputs mid-run have no effect. The timeout
  // counter restarts on every entry to ISSUE; an acknowledge in the final
  // allowed cycle still counts.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    stride_d  = stride_q;
    loopLen_d = loopLen_q;
    numAcc_d  = numAcc_q;
    issued_d  = issued_q;
    tmo_d     = tmo_q;
    loadAddr  = 1'b0;
    stepAddr  = 1'b0;
    issuedNext = issued_q + CNT_W'(1);

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d   = LOAD;
          mode_d    = mode_e'(mode_i);
          base_d    = base_addr_i;
          stride_d  = stride_i;
          loopLen_d = loop_len_i;
          numAcc_d  = num_accesses_i;
          issued_d  = '0;
        end
      end
      LOAD: begin
        loadAddr = 1'b1;
        tmo_d    = '0;
        state_d  = (numAcc_q == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (bus.updated) begin
          if (issued_q < numAcc_q) begin
            issued_d = issuedNext;
          end
          state_d = (issuedNext >= numAcc_q) ? DONE : GAP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GAP: begin
        stepAddr = 1'b1;
        tmo_d    = '0;
        state_d  = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= SEQ;
      base_q    <= '0;
      stride_q  <= '0;
      loopLen_q <= '0;
      numAcc_q  <= '0;
      issued_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      loopLen_q <= loopLen_d;
      numAcc_q  <= numAcc_d;
      issued_q  <= issued_d;
      tmo_q     <= tmo_d;
    end
  end

  trace_addr_gen #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .RAND_MASK (RAND_MASK)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load_i     (loadAddr),
    .step_i     (stepAddr),
    .mode_i     (mode_q),
    .base_i     (base_q),
    .stride_i   (stride_q),
    .loop_len_i (loopLen_q),
    .addr_o     (genAddr)
  );

  // Status outputs decode straight from the registered state.
  assign bus.trace_ready = (state_q == ISSUE);
  assign bus.mem_addr    = genAddr;
  assign busy_o          = (state_q == LOAD) || (state_q == ISSUE) || (state_q == GAP);
  assign done_o          = (state_q == DONE);
  assign timeout_err_o   = (state_q == ERROR);
  assign issued_count_o  = issued_q;

endmodule

// File: tb/tb_trace_feeder.sv
// tb_trace_feeder: directed self-checking bench for trace_feeder.
module tb_trace_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] baseAddr = '0;
  logic [31:0] stride = '0;
  logic [15:0] loopLen = '0;
  logic [15:0] numAcc = '0;
  logic        busy;
  logic        done;
  logic        timeoutErr;
  logic [15:0] issuedCount;

  int checks = 0;
  int errors = 0;

  trace_feeder_if #(.ADDR_W(32)) bus ();

  trace_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .mode_i         (mode),
    .base_addr_i    (baseAddr),
    .stride_i       (stride),
    .loop_len_i     (loopLen),
    .num_accesses_i (numAcc),
    .bus            (bus),
    .busy_o         (busy),
    .done_o         (done),
    .timeout_err_o  (timeoutErr),
    .issued_count_o (issuedCount)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [1:0]       mode;
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [15:0]      loopLen;
    logic [15:0]      num;
    logic [7:0][31:0] expAddr;
  } vector_t;

  vector_t vecs [7];

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present a configuration and pulse start for one cycle; returns in LOAD
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] b, input logic [31:0] s,
                               input logic [15:0] l, input logic [15:0] n);
    mode     = m;
    baseAddr = b;
    stride   = s;
    loopLen  = l;
    numAcc   = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Independent reference for the Galois LFSR (taps 32,22,2,1)
  function automatic logic [31:0] refLfsr(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic vector_t mkVec(input string name, input logic [1:0] m, input logic [31:0] b,
                                    input logic [31:0] s, input logic [15:0] l, input logic [15:0] n,
                                    input logic [31:0] e0 = 0, input logic [31:0] e1 = 0,
                                    input logic [31:0] e2 = 0, input logic [31:0] e3 = 0,
                                    input logic [31:0] e4 = 0, input logic [31:0] e5 = 0,
                                    input logic [31:0] e6 = 0, input logic [31:0] e7 = 0);
    vector_t v;
    v.name = name; v.mode = m; v.base = b; v.stride = s; v.loopLen = l; v.num = n;
    v.expAddr[0] = e0; v.expAddr[1] = e1; v.expAddr[2] = e2; v.expAddr[3] = e3;
    v.expAddr[4] = e4; v.expAddr[5] = e5; v.expAddr[6] = e6; v.expAddr[7] = e7;
    return v;
  endfunction

  // Full run with immediate acknowledges: checks latency, each address, the
  // low cycle between addresses and the final status.
  task automatic runVector(input vector_t v);
    applyStimulus(v.mode, v.base, v.stride, v.loopLen, v.num);
    checkOutput({v.name, " load ready"}, 32'(bus.trace_ready), 32'd0);
    checkOutput({v.name, " load busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < int'(v.num); i++) begin
      tick();
      checkOutput($sformatf("%s ready[%0d]", v.name, i), 32'(bus.trace_ready), 32'd1);
      checkOutput($sformatf("%s addr[%0d]", v.name, i), bus.mem_addr, v.expAddr[i]);
      bus.updated = 1'b1;
      tick();
      bus.updated = 1'b0;
      checkOutput($sformatf("%s gap[%0d]", v.name, i), 32'(bus.trace_ready), 32'd0);
    end
    checkOutput({v.name, " done"}, 32'(done), 32'd1);
    checkOutput({v.name, " busy end"}, 32'(busy), 32'd0);
    checkOutput({v.name, " count"}, 32'(issuedCount), 32'(v.num));
  endtask

  initial begin
    logic [31:0] s;
    int          hiCount;
    vector_t     v;

    bus.updated = 1'b0;

    vecs[0] = mkVec("seq", 2'd0, 32'h0000_1000, 32'd4, 16'd0, 16'd4,
                    32'h1000, 32'h1004, 32'h1008, 32'h100C);
    vecs[1] = mkVec("loop", 2'd1, 32'h0000_2000, 32'h40, 16'd3, 16'd7,
                    32'h2000, 32'h2040, 32'h2080, 32'h2000, 32'h2040, 32'h2080, 32'h2000);
    vecs[2] = mkVec("wrap", 2'd0, 32'hFFFF_FFFC, 32'd8, 16'd0, 16'd2,
                    32'hFFFF_FFFC, 32'h0000_0004);
    vecs[3] = mkVec("rand0", 2'd2, 32'h0, 32'd0, 16'd0, 16'd4);
    vecs[4] = mkVec("randS", 2'd2, 32'h1234_5678, 32'd0, 16'd0, 16'd6);
    vecs[5] = mkVec("rsvd", 2'd3, 32'h0000_0100, 32'h10, 16'd0, 16'd3,
                    32'h100, 32'h110, 32'h120);
    vecs[6] = mkVec("loop0", 2'd1, 32'h0000_3000, 32'd4, 16'd0, 16'd3,
                    32'h3000, 32'h3000, 32'h3000);

    // Random-mode expectations come from the reference LFSR
    for (int k = 3; k <= 4; k++) begin
      s = (vecs[k].base == 0) ? 32'h1 : vecs[k].base;
      for (int i = 0; i < int'(vecs[k].num); i++) begin
        vecs[k].expAddr[i] = s & 32'h0000_FFFC;
        s = refLfsr(s);
      end
    end

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst ready", 32'(bus.trace_ready), 32'd0);
    checkOutput("rst addr", bus.mem_addr, 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst err", 32'(timeoutErr), 32'd0);
    checkOutput("rst count", 32'(issuedCount), 32'd0);

    // Acknowledge while idle must be ignored
    bus.updated = 1'b1;
    tick();
    bus.updated = 1'b0;
    checkOutput("idle upd count", 32'(issuedCount), 32'd0);
    checkOutput("idle upd busy", 32'(busy), 32'd0);

    $display("[TB] table vectors");
    for (int k = 0; k < 7; k++) runVector(vecs[k]);

    $display("[TB] zero-length run");
    applyStimulus(2'd0, 32'h500, 32'd4, 16'd0, 16'd0);
    checkOutput("num0 busy", 32'(busy), 32'd1);
    checkOutput("num0 done early", 32'(done), 32'd0);
    checkOutput("num0 count clr", 32'(issuedCount), 32'd0);
    tick();
    checkOutput("num0 done", 32'(done), 32'd1);
    checkOutput("num0 ready", 32'(bus.trace_ready), 32'd0);
    checkOutput("num0 busy end", 32'(busy), 32'd0);

    $display("[TB] start while busy, acknowledge in gap");
    applyStimulus(2'd0, 32'h4000, 32'h10, 16'd0, 16'd3);
    tick();
    checkOutput("busy addr0", bus.mem_addr, 32'h4000);
    mode = 2'd1; baseAddr = 32'h9999_0000; numAcc = 16'd1;
    start = 1'b1;
    bus.updated = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy gap ready", 32'(bus.trace_ready), 32'd0);
    tick();
    bus.updated = 1'b0;
    checkOutput("gap upd count", 32'(issuedCount), 32'd1);
    checkOutput("busy addr1", bus.mem_addr, 32'h4010);
    checkOutput("busy ready1", 32'(bus.trace_ready), 32'd1);
    bus.updated = 1'b1;
    tick();
    bus.updated = 1'b0;
    tick();
    checkOutput("busy addr2", bus.mem_addr, 32'h4020);
    bus.updated = 1'b1;
    tick();
    bus.updated = 1'b0;
    checkOutput("busy count", 32'(issuedCount), 32'd3);
    checkOutput("busy done", 32'(done), 32'd1);

    $display("[TB] timeout");
    applyStimulus(2'd0, 32'h7000, 32'd4, 16'd0, 16'd2);
    tick();
    hiCount = 0;
    while (bus.trace_ready && hiCount < 400) begin
      hiCount++;
      tick();
    end
    checkOutput("tmo cycles", 32'(hiCount), 32'd255);
    checkOutput("tmo err", 32'(timeoutErr), 32'd1);
    checkOutput("tmo busy", 32'(busy), 32'd0);
    checkOutput("tmo ready", 32'(bus.trace_ready), 32'd0);
    checkOutput("tmo addr hold", bus.mem_addr, 32'h7000);
    checkOutput("tmo count", 32'(issuedCount), 32'd0);
    applyStimulus(2'd0, 32'h7100, 32'd4, 16'd0, 16'd1);
    checkOutput("tmo err clr", 32'(timeoutErr), 32'd0);
    tick();
    checkOutput("tmo restart addr", bus.mem_addr, 32'h7100);
    bus.updated = 1'b1;
    tick();
    bus.updated = 1'b0;
    checkOutput("tmo restart done", 32'(done), 32'd1);

    $display("[TB] reset mid-run");
    applyStimulus(2'd0, 32'h100, 32'd4, 16'd0, 16'd5);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("mid addr[%0d]", i), bus.mem_addr, 32'h100 + 32'(i * 4));
      bus.updated = 1'b1;
      tick();
      bus.updated = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid rst ready", 32'(bus.trace_ready), 32'd0);
    checkOutput("mid rst addr", bus.mem_addr, 32'd0);
    checkOutput("mid rst busy", 32'(busy), 32'd0);
    checkOutput("mid rst count", 32'(issuedCount), 32'd0);
    tick();
    checkOutput("mid idle ready", 32'(bus.trace_ready), 32'd0);
    v = mkVec("rerun", 2'd0, 32'h100, 32'd4, 16'd0, 16'd5,
              32'h100, 32'h104, 32'h108, 32'h10C, 32'h110);
    runVector(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
